// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared defaults, pointer wrap helper and stats counter type for
//            the FIFO read-stream drain engine.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SKID_DEPTH = 2;

    // Widest pointer needed for the largest legal skid depth (4 entries).
    localparam int PTR_MAX_W = 2;

    typedef logic [15:0] stats_t;
    localparam stats_t STATS_MAX = 16'hFFFF;

    function automatic logic [PTR_MAX_W-1:0] ptr_inc(
        input logic [PTR_MAX_W-1:0] ptr,
        input int                   depth
    );
        logic [PTR_MAX_W-1:0] last;
        last = PTR_MAX_W'(depth - 1);
        return (ptr == last) ? '0 : (ptr + PTR_MAX_W'(1));
    endfunction

    function automatic stats_t sat_inc(input stats_t v);
        return (v == STATS_MAX) ? v : (v + 16'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Brief    : Circular skid buffer holding words captured from the FIFO until
//            the downstream consumer accepts them.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int SKID_DEPTH = DEF_SKID_DEPTH,
    localparam int PTR_W      = $clog2(SKID_DEPTH),
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [PTR_W-1:0] w_wr_ptr_inc;
    logic             w_do_pop;

    always_comb begin
        w_rd_ptr_inc = PTR_W'(ptr_inc(PTR_MAX_W'(r_rd_ptr), SKID_DEPTH));
        w_wr_ptr_inc = PTR_W'(ptr_inc(PTR_MAX_W'(r_wr_ptr), SKID_DEPTH));
        w_do_pop     = pop && (r_count != '0);
    end

    // Flush discards everything held; a word being captured this edge is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(w_do_pop);
        end
    end

    // Storage is cleared only on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Drains the 8-bit synchronous FIFO read port into a valid/ready
//            stream at up to one word per clock. Optional transfer/stall
//            statistics are enabled with FIFO_RD_STREAM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_e,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_re,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [15:0]      xfer_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic             r_inflight;
    logic [CNT_W-1:0] w_count;
    logic [WIDTH-1:0] w_head;
    logic             w_pop;
    logic [OCC_W-1:0] w_occ;
    logic             w_re;

    // Occupancy after this edge, counting the word still returning from the FIFO.
    always_comb begin
        w_pop = out_valid && out_ready;
        w_occ = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
        w_re  = !rst && !flush && !fifo_e && (w_occ < OCC_W'(SKID_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_re;
        end
    end

    fifo_rd_skid #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (r_inflight),
        .push_data (fifo_dout),
        .pop       (w_pop),
        .count     (w_count),
        .head_data (w_head)
    );

    assign fifo_re   = w_re;
    assign out_valid = (w_count != '0);
    assign out_data  = w_head;

`ifdef FIFO_RD_STREAM_STATS_EN
    stats_t r_xfer_cnt;
    stats_t r_stall_cnt;

    // Statistics survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_xfer_cnt <= sat_inc(r_xfer_cnt);
            end
            if (out_valid && !out_ready) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign xfer_cnt  = r_xfer_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Self-checking bench; drives two instances (skid depth 2 and 3)
//            from behavioural FIFO models and checks the delivered streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       e0 = 1'b1, e1 = 1'b1;
    logic [7:0] d0 = '0, d1 = '0;
    logic       re0, re1, v0, v1;
    logic [7:0] od0, od1;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] xc0, sc0, xc1, sc1;
`endif

    fifo_rd_stream #(.WIDTH(8), .SKID_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .fifo_e(e0), .fifo_dout(d0), .fifo_re(re0),
        .flush(flush), .out_valid(v0), .out_ready(out_ready), .out_data(od0)
`ifdef FIFO_RD_STREAM_STATS_EN
        , .xfer_cnt(xc0), .stall_cnt(sc0)
`endif
    );

    fifo_rd_stream #(.WIDTH(8), .SKID_DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .fifo_e(e1), .fifo_dout(d1), .fifo_re(re1),
        .flush(flush), .out_valid(v1), .out_ready(out_ready), .out_data(od1)
`ifdef FIFO_RD_STREAM_STATS_EN
        , .xfer_cnt(xc1), .stall_cnt(sc1)
`endif
    );

    always #5 clk = ~clk;

    // FIFO contents, expected streams and delivered streams per instance
    logic [7:0] q0[$], q1[$];
    logic [7:0] expq0[$], expq1[$];
    logic [7:0] g0[$], g1[$];
    int         gc0[$];
    int cyc = 0, reads0 = 0, reads1 = 0;
    int checks = 0, failures = 0;
    int t0, hold_bad, idle_re, idle_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then let the FIFO models answer reads.
    task automatic step();
        logic r0, r1;
        @(negedge clk);
        chk("no_underflow_d2", 32'(re0 & e0), 0);
        chk("no_underflow_d3", 32'(re1 & e1), 0);
        if (v0 && out_ready) begin
            g0.push_back(od0);
            gc0.push_back(cyc);
        end
        if (v1 && out_ready) g1.push_back(od1);
        r0 = re0;
        r1 = re1;
        if (r0) reads0++;
        if (r1) reads1++;
        @(posedge clk);
        #1;
        cyc++;
        if (r0 && q0.size() > 0) d0 = q0.pop_front();
        if (r1 && q1.size() > 0) d1 = q1.pop_front();
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        q0.delete(); q1.delete(); expq0.delete(); expq1.delete();
        e0 = 1'b1; e1 = 1'b1;
        d0 = 8'($urandom); d1 = 8'($urandom);
        step(); step();
        rst = 1'b0;
        g0.delete(); g1.delete(); gc0.delete();
        reads0 = 0; reads1 = 0;
    endtask

    task automatic load_word(input logic [7:0] w);
        q0.push_back(w); q1.push_back(w);
        expq0.push_back(w); expq1.push_back(w);
        e0 = 1'b0; e1 = 1'b0;
    endtask

    task automatic load_seq(input int first, input int n);
        for (int i = 0; i < n; i++) load_word(8'(first + i));
    endtask

    // mode: 0 ready held high, 1 toggling, 2 random
    task automatic drain(input int maxcyc, input int mode);
        int k;
        k = 0;
        while ((g0.size() < expq0.size() || g1.size() < expq1.size()) && k < maxcyc) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (k % 2 == 0);
            else                out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic check_order(input string tag, input int which);
        logic [7:0] g[$];
        logic [7:0] x[$];
        if (which == 0) begin g = g0; x = expq0; end
        else begin g = g1; x = expq1; end
        chk({tag, "_len"}, 32'(g.size()), 32'(x.size()));
        for (int i = 0; i < x.size() && i < g.size(); i++) chk(tag, 32'(g[i]), 32'(x[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset dominates a non-empty FIFO
        load_word(8'h55);
        step(); step();
        #1;
        chk("rst_re", 32'(re0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_data", 32'(od0), 0);
        chk("rst_valid_d3", 32'(v1), 0);

        // Empty FIFO for 10 clocks
        do_reset();
        idle_re = 0; idle_v = 0;
        repeat (10) begin
            step(); #1;
            if (re0 || re1) idle_re++;
            if (v0 || v1) idle_v++;
        end
        chk("idle_re", 32'(idle_re), 0);
        chk("idle_valid", 32'(idle_v), 0);
        chk("idle_data", 32'(od0), 0);

        // Full-rate stream of 1..8
        do_reset();
        out_ready = 1'b1;
        load_seq(1, 8);
        t0 = cyc;
        drain(40, 0);
        check_order("stream_d2", 0);
        check_order("stream_d3", 1);
        chk("first_latency", (gc0.size() > 0) ? 32'(gc0[0] - t0) : 32'hFFFF_FFFF, 2);
        chk("back_to_back", (gc0.size() == 8) ? 32'(gc0[7] - gc0[0]) : 32'hFFFF_FFFF, 7);
        chk("reads_total", 32'(reads0), 8);

        // Stall for 6 clocks then release
        do_reset();
        load_seq(1, 8);
        hold_bad = 0;
        repeat (6) begin
            step(); #1;
            if (v0 && od0 != 8'd1) hold_bad++;
        end
        chk("stall_reads_d2", 32'(reads0), 2);
        chk("stall_reads_d3", 32'(reads1), 3);
        chk("stall_valid", 32'(v0), 1);
        chk("stall_hold", 32'(hold_bad), 0);
        chk("stall_data", 32'(od0), 1);
        drain(40, 0);
        check_order("after_stall_d2", 0);
        check_order("after_stall_d3", 1);
        chk("after_stall_gapless", (gc0.size() == 8) ? 32'(gc0[7] - gc0[0]) : 32'hFFFF_FFFF, 7);

        // Toggling ready with 10..19
        do_reset();
        load_seq(10, 10);
        drain(80, 1);
        check_order("toggle_d2", 0);
        check_order("toggle_d3", 1);

        // Random words, random ready
        do_reset();
        for (int i = 0; i < int'($urandom_range(20, 40)); i++) load_word(8'($urandom));
        drain(400, 2);
        check_order("random_d2", 0);
        check_order("random_d3", 1);

        // Flush with words held and (depth-3 instance) 7 in flight
        do_reset();
        load_seq(5, 8);
        repeat (3) step();
        expq0 = q0;
        expq1 = q1;
        flush = 1'b1;
        #1;
        chk("flush_re_d2", 32'(re0), 0);
        chk("flush_re_d3", 32'(re1), 0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid_d2", 32'(v0), 0);
        chk("flush_valid_d3", 32'(v1), 0);
        drain(40, 0);
        chk("flush_next_d3", (g1.size() > 0) ? 32'(g1[0]) : 32'hFFFF_FFFF, 8);
        check_order("flush_d2", 0);
        check_order("flush_d3", 1);

        // Reset mid-transfer
        do_reset();
        load_seq(1, 4);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(v0), 0);
        chk("midrst_data", 32'(od0), 0);
        chk("midrst_data_d3", 32'(od1), 0);

`ifdef FIFO_RD_STREAM_STATS_EN
        do_reset();
        out_ready = 1'b1;
        load_seq(1, 20);
        repeat (4) step();
        out_ready = 1'b0;
        repeat (3) step();
        drain(60, 0);
        chk("xfer_cnt", 32'(xc0), 20);
        chk("stall_cnt", 32'(sc0), 3);
        chk("xfer_cnt_d3", 32'(xc1), 20);
        do_reset();
        #1;
        chk("xfer_cnt_rst", 32'(xc0), 0);
        chk("stall_cnt_rst", 32'(sc0), 0);
        load_seq(0, 65540);
        drain(70000, 0);
        chk("xfer_cnt_sat", 32'(xc0), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
